// File: rtl/fetch_pc_pkg.sv
// Shared types and constants for the fetch PC stage.
// State encoding, reset defaults and redirect alignment mask.
package fetch_pc_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DROP  = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_target(input logic [31:0] a);
        return a & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_pc_stage_if_id_reg.sv
// IF/ID pipeline register {instr, pc_plus4, valid}.
// Ports: clk_i, rst_ni, load_i, flush_i, stall_i, instr_i, pcplus4_i, instr_o, pcplus4_o, valid_o.
module if_id_reg
    import fetch_pc_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pcplus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pcplus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pcplus4_q;
    logic        valid_q;

    // Flush and bubble touch only valid; stale payload is harmless.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= 32'h0;
            valid_q   <= 1'b0;
        end else if (flush_i) begin
            valid_q   <= 1'b0;
        end else if (load_i) begin
            instr_q   <= instr_i;
            pcplus4_q <= pcplus4_i;
            valid_q   <= 1'b1;
        end else if (!stall_i) begin
            valid_q   <= 1'b0;
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch front end: PC register, imem request FSM and IF/ID load control.
// Ports: Clk, Reset(n), PC out/+4 in, Stall, branch/jump redirect, imem req/ack, IF/ID outputs.
module fetch_pc_stage
    import fetch_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] PCResult,
    input  logic [31:0] PCAddResult,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] IfIdInstr,
    output logic [31:0] IfIdPCPlus4,
    output logic        IfIdValid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_q, hold_d;
    logic [31:0]  drop_q, drop_d;

    logic        redirect;
    logic [31:0] target;
    logic        ack;
    logic        load;
    logic        flush;
    logic [31:0] load_instr;

    assign redirect = BranchTaken | Jump;
    assign target   = align_target(BranchTaken ? BranchTarget : JumpTarget);
    assign ack      = ImemAck & ImemReq;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        drop_d     = drop_q;
        load       = 1'b0;
        flush      = 1'b0;
        load_instr = ImemData;
        ImemReq    = 1'b1;
        ImemAddr   = pc_q;
        unique case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    pc_d  = target;
                    flush = 1'b1;
                    // Outstanding fetch must finish before the new one starts.
                    if (!ack) begin
                        drop_d  = pc_q;
                        state_d = S_DROP;
                    end
                end else if (ack && !Stall) begin
                    load = 1'b1;
                    pc_d = PCAddResult;
                end else if (ack) begin
                    hold_d  = ImemData;
                    state_d = S_HOLD;
                end
            end
            S_DROP: begin
                ImemAddr = drop_q;
                if (ack) state_d = S_FETCH;
                if (redirect) begin
                    pc_d  = target;
                    flush = 1'b1;
                end
            end
            S_HOLD: begin
                ImemReq    = 1'b0;
                load_instr = hold_q;
                if (redirect) begin
                    pc_d    = target;
                    flush   = 1'b1;
                    state_d = S_FETCH;
                end else if (!Stall) begin
                    load    = 1'b1;
                    pc_d    = PCAddResult;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            hold_q  <= 32'h0;
            drop_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            drop_q  <= drop_d;
        end
    end

    assign PCResult = pc_q;

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk_i    (Clk),
        .rst_ni   (Reset),
        .load_i   (load),
        .flush_i  (flush),
        .stall_i  (Stall),
        .instr_i  (load_instr),
        .pcplus4_i(PCAddResult),
        .instr_o  (IfIdInstr),
        .pcplus4_o(IfIdPCPlus4),
        .valid_o  (IfIdValid)
    );

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed testbench for fetch_pc_stage.
// External +4 adder modelled here; memory ack/data driven by hand.
module tb_fetch_pc_stage;

    logic        Clk;
    logic        Reset;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic [31:0] IfIdInstr;
    logic [31:0] IfIdPCPlus4;
    logic        IfIdValid;

    int n_cmp;
    int n_err;

    fetch_pc_stage dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .PCResult    (PCResult),
        .PCAddResult (PCAddResult),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump        (Jump),
        .JumpTarget  (JumpTarget),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemAck     (ImemAck),
        .ImemData    (ImemData),
        .IfIdInstr   (IfIdInstr),
        .IfIdPCPlus4 (IfIdPCPlus4),
        .IfIdValid   (IfIdValid)
    );

    assign PCAddResult = PCResult + 32'd4;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] i,
                            input logic [31:0] p4, input logic v);
        chk({tag, ".instr"}, IfIdInstr, i);
        chk({tag, ".pc4"}, IfIdPCPlus4, p4);
        chk({tag, ".valid"}, {31'h0, IfIdValid}, {31'h0, v});
    endtask

    logic [31:0] exp_a [3];

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b0;
        Stall = 1'b0;
        BranchTaken = 1'b0;
        BranchTarget = 32'h0;
        Jump = 1'b0;
        JumpTarget = 32'h0;
        ImemAck = 1'b0;
        ImemData = 32'h0;
        exp_a[0] = 32'hA0;
        exp_a[1] = 32'hA1;
        exp_a[2] = 32'hA2;

        #1;
        chk("rst.pc", PCResult, 32'h0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        #1;
        Reset = 1'b1;
        chk("rel.req", {31'h0, ImemReq}, 32'h1);
        chk("rel.addr", ImemAddr, 32'h0);

        // zero-wait stream
        ImemAck = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ImemData = exp_a[k];
            step();
            chk_ifid("zw", exp_a[k], 32'(4 * (k + 1)), 1'b1);
            chk("zw.pc", PCResult, 32'(4 * (k + 1)));
        end

        ImemData = 32'hA3;
        step();
        chk("pc10", PCResult, 32'h10);

        // three-cycle wait at 0x10
        ImemAck = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wait.addr", ImemAddr, 32'h10);
            chk("wait.valid", {31'h0, IfIdValid}, 32'h0);
        end
        ImemAck = 1'b1;
        ImemData = 32'hB0;
        step();
        chk_ifid("late", 32'hB0, 32'h14, 1'b1);
        chk("late.pc", PCResult, 32'h14);

        for (int k = 0; k < 3; k++) begin
            ImemData = 32'hC0 + 32'(k);
            step();
        end
        chk("pc20", PCResult, 32'h20);

        // stall at ack -> HOLD
        ImemData = 32'hD0;
        Stall = 1'b1;
        step();
        chk("hold.req", {31'h0, ImemReq}, 32'h0);
        chk("hold.pc", PCResult, 32'h20);
        chk_ifid("hold", 32'hC2, 32'h20, 1'b1);
        ImemData = 32'hEE;
        step();
        chk("hold2.req", {31'h0, ImemReq}, 32'h0);
        chk("hold2.pc", PCResult, 32'h20);
        Stall = 1'b0;
        ImemAck = 1'b0;
        step();
        chk_ifid("unhold", 32'hD0, 32'h24, 1'b1);
        chk("unhold.pc", PCResult, 32'h24);
        chk("unhold.req", {31'h0, ImemReq}, 32'h1);

        ImemAck = 1'b1;
        for (int k = 0; k < 7; k++) begin
            ImemData = 32'hE0 + 32'(k);
            step();
        end
        chk("pc40", PCResult, 32'h40);

        // jump while 0x40 outstanding -> DROP
        ImemAck = 1'b0;
        Jump = 1'b1;
        JumpTarget = 32'h100;
        step();
        Jump = 1'b0;
        chk("drop.pc", PCResult, 32'h100);
        chk("drop.addr", ImemAddr, 32'h40);
        chk("drop.valid", {31'h0, IfIdValid}, 32'h0);
        step();
        chk("drop2.addr", ImemAddr, 32'h40);
        chk("drop2.valid", {31'h0, IfIdValid}, 32'h0);
        ImemAck = 1'b1;
        ImemData = 32'hDEAD;
        step();
        chk("undrop.addr", ImemAddr, 32'h100);
        chk("undrop.valid", {31'h0, IfIdValid}, 32'h0);
        chk("undrop.pc", PCResult, 32'h100);

        // async reset mid-DROP
        ImemAck = 1'b0;
        Jump = 1'b1;
        JumpTarget = 32'h180;
        step();
        Jump = 1'b0;
        chk("drop3.addr", ImemAddr, 32'h100);
        #1;
        Reset = 1'b0;
        #1;
        chk("arst.pc", PCResult, 32'h0);
        chk("arst.addr", ImemAddr, 32'h0);
        chk("arst.req", {31'h0, ImemReq}, 32'h1);
        chk_ifid("arst", 32'h0, 32'h0, 1'b0);
        #1;
        Reset = 1'b1;

        // branch beats jump, overrides stall
        ImemAck = 1'b1;
        ImemData = 32'hF0;
        step();
        chk_ifid("pre", 32'hF0, 32'h4, 1'b1);
        BranchTaken = 1'b1;
        BranchTarget = 32'h200;
        Jump = 1'b1;
        JumpTarget = 32'h300;
        Stall = 1'b1;
        step();
        chk("bj.pc", PCResult, 32'h200);
        chk("bj.valid", {31'h0, IfIdValid}, 32'h0);
        chk("bj.addr", ImemAddr, 32'h200);
        Jump = 1'b0;
        Stall = 1'b0;
        BranchTarget = 32'h203;
        step();
        chk("align.pc", PCResult, 32'h200);
        BranchTaken = 1'b0;

        // wrap at top of address space
        Jump = 1'b1;
        JumpTarget = 32'hFFFF_FFFC;
        step();
        Jump = 1'b0;
        ImemData = 32'h77;
        step();
        chk("wrap.pc", PCResult, 32'h0);
        chk_ifid("wrap", 32'h77, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
